// File: rtl/debounce_pkg.sv
// Shared definitions for the button debounce bank: per-channel state encoding
// and default timing constants for the 100 MHz board clock.
package debounce_pkg;

    localparam int CLK_HZ            = 100_000_000;
    localparam int DEF_STABLE_CYCLES = 1_000_000;   // 10 ms
    localparam int DEF_HOLD_CYCLES   = 50_000_000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES = 10_000_000;  // 100 ms

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } ch_state_e;

    // Width of a counter that must be able to hold the value max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, stable-level counter, and the
// press/hold/auto-repeat state machine.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input  logic      clock,
    input  logic      resetn,
    input  logic      in_raw,
    output logic      level,
    output logic      press_pulse,
    output logic      release_pulse,
    output logic      repeat_pulse,
    output ch_state_e state
);

    localparam int SW = cnt_width(STABLE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);

    logic          sync_meta;
    logic          sync;
    logic [SW-1:0] stab_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          flip;
    logic          rise;
    logic          fall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= in_raw;
            sync      <= sync_meta;
        end
    end

    // The level flips on the edge where the disagreement has lasted
    // STABLE_CYCLES consecutive samples.
    assign flip = (sync != level) && (stab_cnt == STABLE_LAST);
    assign rise = flip && !level;
    assign fall = flip && level;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stab_cnt      <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync != level) begin
                if (flip) begin
                    level         <= ~level;
                    stab_cnt      <= '0;
                    press_pulse   <= ~level;
                    release_pulse <= level;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    // Hold/repeat state machine; a debounced release wins over any hold or
    // repeat event on the same edge so held falls together with level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                    if (rise) begin
                        state <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (fall) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                        rep_cnt  <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state        <= ST_HELD;
                        hold_cnt     <= HOLD_MAX;
                        rep_cnt      <= '0;
                        repeat_pulse <= (REPEAT_EN != 0);
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                        rep_cnt  <= '0;
                    end else if (rep_cnt == REPEAT_LAST) begin
                        rep_cnt      <= '0;
                        repeat_pulse <= (REPEAT_EN != 0);
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounced buttons with press/release pulses,
// long-press detection and auto-repeat.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] repeat_pulse
);

    ch_state_e ch_state [N_CH];

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            debounce_channel #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES),
                .REPEAT_EN     (REPEAT_EN)
            ) u_ch (
                .clock         (clock),
                .resetn        (resetn),
                .in_raw        (in_raw[i]),
                .level         (level[i]),
                .press_pulse   (press_pulse[i]),
                .release_pulse (release_pulse[i]),
                .repeat_pulse  (repeat_pulse[i]),
                .state         (ch_state[i])
            );

            // held is a decode of the registered state, so it moves on the
            // same edges as the state machine.
            assign held[i] = (ch_state[i] == ST_HELD);
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus random
// button traffic against a sample-history reference model.
module tb_debounce_bank;

    localparam int N      = 2;
    localparam int STABLE = 4;
    localparam int HOLD   = 10;
    localparam int REP    = 3;
    localparam int VW     = 5 * N;

    logic         clock = 1'b0;
    logic         resetn;
    logic [N-1:0] in_raw;

    logic [N-1:0] level_a, press_a, rel_a, held_a, rep_a;
    logic [N-1:0] level_b, press_b, rel_b, held_b, rep_b;

    int total = 0;
    int bad   = 0;

    debounce_bank #(
        .N_CH(N), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) u_dut (
        .clock(clock), .resetn(resetn), .in_raw(in_raw),
        .level(level_a), .press_pulse(press_a), .release_pulse(rel_a),
        .held(held_a), .repeat_pulse(rep_a)
    );

    debounce_bank #(
        .N_CH(N), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) u_dut_norep (
        .clock(clock), .resetn(resetn), .in_raw(in_raw),
        .level(level_b), .press_pulse(press_b), .release_pulse(rel_b),
        .held(held_b), .repeat_pulse(rep_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Level changes once the last STABLE synchronized samples all disagree
    // with it; hold/repeat are derived from the age of the current press.
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_held, m_rep;
    int           m_age  [N];
    bit           m_hist [N][$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0;
        m_rel = '0; m_held = '0; m_rep = '0;
        for (int c = 0; c < N; c++) begin
            m_age[c] = 0;
            m_hist[c].delete();
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic rs);
        bit old_s2;
        bit all_diff;
        if (!rs) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            old_s2 = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
            m_hist[c].push_back(old_s2);
            if (m_hist[c].size() > STABLE) void'(m_hist[c].pop_front());
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            all_diff = (m_hist[c].size() == STABLE);
            for (int j = 0; j < m_hist[c].size(); j++)
                if (m_hist[c][j] == m_level[c]) all_diff = 0;
            if (all_diff) begin
                m_level[c] = ~m_level[c];
                m_press[c] = m_level[c];
                m_rel[c]   = ~m_level[c];
                m_age[c]   = 0;
            end else if (m_level[c]) begin
                m_age[c]++;
            end
            m_held[c] = m_level[c] && (m_age[c] >= HOLD);
            m_rep[c]  = m_held[c] && (((m_age[c] - HOLD) % REP) == 0);
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input bit rep_en);
        logic [N-1:0] r;
        r = rep_en ? m_rep : '0;
        return {m_level, m_press, m_rel, m_held, r};
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        logic [N-1:0] raw;
        logic         rs;
        raw = in_raw;
        rs  = resetn;
        @(posedge clock);
        model_edge(raw, rs);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        in_raw = '0;
        model_reset();
        tick();
        tick();
        total++;
        if ({level_a, press_a, rel_a, held_a, rep_a} !== '0) begin
            bad++;
            $display("FAIL reset_a: got %b want 0", {level_a, press_a, rel_a, held_a, rep_a});
        end
        total++;
        if ({level_b, press_b, rel_b, held_b, rep_b} !== '0) begin
            bad++;
            $display("FAIL reset_b: got %b want 0", {level_b, press_b, rel_b, held_b, rep_b});
        end
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_press();
        in_raw = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if ({level_a, press_a, rel_a, held_a, rep_a} !== exp_vec(1)) begin
                bad++;
                $display("FAIL press_model_a k=%0d: got %b want %b", k,
                         {level_a, press_a, rel_a, held_a, rep_a}, exp_vec(1));
            end
            total++;
            if ({level_a[0], press_a[0], level_a[1]} !== {1'(k >= 6), 1'(k == 6), 1'b0}) begin
                bad++;
                $display("FAIL press_edge6 k=%0d: got lvl0=%b prs0=%b lvl1=%b want %b %b 0",
                         k, level_a[0], press_a[0], level_a[1], k >= 6, k == 6);
            end
        end
        in_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if ({level_a, press_a, rel_a, held_a, rep_a} !== exp_vec(1)) begin
                bad++;
                $display("FAIL release_model_a k=%0d: got %b want %b", k,
                         {level_a, press_a, rel_a, held_a, rep_a}, exp_vec(1));
            end
        end
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) begin
                in_raw = (k < 3) ? 2'b01 : 2'b00;
                tick();
                total++;
                if ({level_a[0], press_a[0], rel_a[0]} !== 3'b000 ||
                    {level_a, press_a, rel_a, held_a, rep_a} !== exp_vec(1)) begin
                    bad++;
                    $display("FAIL glitch r=%0d k=%0d: got %b want %b", r, k,
                             {level_a, press_a, rel_a, held_a, rep_a}, exp_vec(1));
                end
            end
        end
        in_raw = 2'b00;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_hold_repeat();
        int rise_k = -1;
        int held_k = -1;
        int rep_cnt_a = 0;
        int rep_cnt_b = 0;
        int rel_k = -1;
        int rel_cnt = 0;
        in_raw = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (level_a[0] && rise_k < 0) rise_k = k;
            if (held_a[0] && held_k < 0) held_k = k;
            if (rep_a[0]) rep_cnt_a++;
            if (rep_b[0]) rep_cnt_b++;
            total++;
            if ({level_a, press_a, rel_a, held_a, rep_a} !== exp_vec(1)) begin
                bad++;
                $display("FAIL hold_model_a k=%0d: got %b want %b", k,
                         {level_a, press_a, rel_a, held_a, rep_a}, exp_vec(1));
            end
            total++;
            if ({level_b, press_b, rel_b, held_b, rep_b} !== exp_vec(0)) begin
                bad++;
                $display("FAIL hold_model_b k=%0d: got %b want %b", k,
                         {level_b, press_b, rel_b, held_b, rep_b}, exp_vec(0));
            end
        end
        total++;
        if (rise_k != 6 || held_k != 16) begin
            bad++;
            $display("FAIL hold_timing: got rise=%0d held=%0d want 6 16", rise_k, held_k);
        end
        // repeats at edges 16,19,22,25,28
        total++;
        if (rep_cnt_a != 5 || rep_cnt_b != 0) begin
            bad++;
            $display("FAIL repeat_count: got a=%0d b=%0d want 5 0", rep_cnt_a, rep_cnt_b);
        end
        in_raw = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (rel_a[0]) begin
                rel_cnt++;
                rel_k = k;
                total++;
                if (held_a[0] !== 1'b0 || held_b[0] !== 1'b0 || level_a[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL release_held: got held_a=%b held_b=%b lvl=%b want 0 0 0",
                             held_a[0], held_b[0], level_a[0]);
                end
            end
            total++;
            if ({level_a, press_a, rel_a, held_a, rep_a} !== exp_vec(1)) begin
                bad++;
                $display("FAIL hold_release_model_a k=%0d: got %b want %b", k,
                         {level_a, press_a, rel_a, held_a, rep_a}, exp_vec(1));
            end
        end
        total++;
        if (rel_cnt != 1 || rel_k != 6) begin
            bad++;
            $display("FAIL release_once: got count=%0d at=%0d want 1 6", rel_cnt, rel_k);
        end
    endtask

    task automatic test_reset_mid_press();
        int rel_seen = 0;
        in_raw = 2'b01;
        for (int k = 0; k < 8; k++) tick();
        total++;
        if (level_a[0] !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre: got level0=%b want 1", level_a[0]);
        end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        total++;
        if ({level_a, press_a, rel_a, held_a, rep_a, level_b, press_b, rel_b, held_b, rep_b} !== '0) begin
            bad++;
            $display("FAIL midreset_async: got %b %b want all 0",
                     {level_a, press_a, rel_a, held_a, rep_a}, {level_b, press_b, rel_b, held_b, rep_b});
        end
        tick();
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rel_a[0] || rel_b[0]) rel_seen++;
            total++;
            if ({level_a[0], press_a[0]} !== {1'(k >= 6), 1'(k == 6)} ||
                {level_a, press_a, rel_a, held_a, rep_a} !== exp_vec(1)) begin
                bad++;
                $display("FAIL midreset_repress k=%0d: got %b want %b", k,
                         {level_a, press_a, rel_a, held_a, rep_a}, exp_vec(1));
            end
        end
        total++;
        if (rel_seen != 0) begin
            bad++;
            $display("FAIL midreset_norelease: got %0d release pulses want 0", rel_seen);
        end
        in_raw = 2'b00;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_both();
        in_raw = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (press_a !== ((k == 6) ? 2'b11 : 2'b00) || press_b !== press_a) begin
                bad++;
                $display("FAIL both_press k=%0d: got a=%b b=%b want %b", k, press_a, press_b,
                         (k == 6) ? 2'b11 : 2'b00);
            end
        end
        in_raw = 2'b00;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_random();
        int rem [N];
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int t = 0; t < 1200; t++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    in_raw[c] = 1'($urandom_range(0, 1));
                    rem[c] = $urandom_range(1, 24);
                end
                rem[c]--;
            end
            tick();
            total++;
            if ({level_a, press_a, rel_a, held_a, rep_a} !== exp_vec(1)) begin
                bad++;
                $display("FAIL random_a t=%0d: got %b want %b", t,
                         {level_a, press_a, rel_a, held_a, rep_a}, exp_vec(1));
            end
            total++;
            if ({level_b, press_b, rel_b, held_b, rep_b} !== exp_vec(0)) begin
                bad++;
                $display("FAIL random_b t=%0d: got %b want %b", t,
                         {level_b, press_b, rel_b, held_b, rep_b}, exp_vec(0));
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_hold_repeat();
        test_reset_mid_press();
        test_both();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels (1..16).
REQ-002 Parameter STABLE_CYCLES, default 1_000_000: consecutive cycles an input must differ from the debounced level before the level changes (>=1).
REQ-003 Parameter HOLD_CYCLES, default 50_000_000: cycles a pressed level must persist before hold/auto-repeat begins (>=1).
REQ-004 Parameter REPEAT_CYCLES, default 10_000_000: interval between auto-repeat pulses once held (>=1).
REQ-005 Parameter REPEAT_EN, default 1: 1 enables repeat pulses; 0 forces repeat_pulse low.
REQ-006 clock  input  1  system clock, sole clock domain.
REQ-007 resetn  input  1  reset, asynchronous, active-low.
REQ-008 in_raw  input  N_CH  asynchronous raw button levels, 1 = pressed.
REQ-009 level  output  N_CH  debounced button level.
REQ-010 press_pulse  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-011 release_pulse  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-012 held  output  N_CH  high while level has been 1 for >= HOLD_CYCLES.
REQ-013 repeat_pulse  output  N_CH  one-cycle auto-repeat pulse while held.

Function
REQ-014 Each channel SHALL pass in_raw through a two-flop synchronizer (sync); no logic on the first flop output.
REQ-015 Stable counter: sync != level -> increment; sync == level -> clear to 0; counter width $clog2(STABLE_CYCLES+1).
REQ-016 When sync != level and counter == STABLE_CYCLES-1, on that edge level SHALL toggle and counter clear.
REQ-017 A clean step on in_raw sampled at edge 1 SHALL appear on level at edge STABLE_CYCLES+2; any glitch shorter than STABLE_CYCLES cycles (at sync) SHALL not change level.
REQ-018 press_pulse/release_pulse SHALL assert for exactly the one cycle following the edge that changes level (registered, same edge as level update).
REQ-019 Hold counter: counts while level==1, saturates at HOLD_CYCLES; clears when level==0; width $clog2(HOLD_CYCLES+1).
REQ-020 held SHALL rise on the edge the hold counter reaches HOLD_CYCLES and fall on the same edge level falls.
REQ-021 repeat_pulse SHALL fire on the edge held rises, then every REPEAT_CYCLES edges while held; repeat counter clears on release.
REQ-022 press_pulse and repeat_pulse SHALL never assert in the same cycle (HOLD_CYCLES>=1 guarantees).
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous, independent outputs.
REQ-024 Per-channel state machine: IDLE (level 0) -> PRESSED (level 1, counting hold) -> HELD (repeat active) -> IDLE on debounced release from PRESSED or HELD.

Reset
REQ-025 resetn low SHALL asynchronously clear synchronizer flops, all counters, level, held and all pulses to 0, state IDLE.
REQ-026 Reset asserted mid-press SHALL emit no release_pulse; after deassertion a still-pressed input SHALL produce press_pulse at edge STABLE_CYCLES+2.
REQ-027 resetn deassertion is synchronized externally; no internal reset synchronizer.

Structure
REQ-028 Shared package debounce_pkg SHALL hold the state encoding (IDLE, PRESSED, HELD) and default cycle constants for the 100 MHz board clock.
REQ-029 One sub-module debounce_channel (synchronizer, stable counter, hold/repeat FSM), instantiated N_CH times via generate.
REQ-030 Total flops per channel SHALL not exceed 2 + 3 counters + 2 state + 4 output bits.

Verification (STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, N_CH=2)
REQ-031 in_raw[0] 0->1 held -> level[0] rises at edge 6, press_pulse[0] high 1 cycle, in_raw[1] untouched stays 0.
REQ-032 in_raw[0] bursts 1 for 3 cycles, 0 for 2, repeated -> level, pulses stay 0.
REQ-033 in_raw[0] held 1 for 30 cycles -> held rises 10 edges after level, repeat_pulse at +0, +3, +6, ...; release -> release_pulse once, held low same edge.
REQ-034 REPEAT_EN=0, same stimulus -> held behaves identically, repeat_pulse never asserts.
REQ-035 resetn pulsed low while level[0]=1 -> all outputs 0 immediately, no release_pulse; press re-detected at edge 6 after release of reset.
REQ-036 Both channels pressed same cycle -> press_pulse=2'b11 on one cycle.
